// File: rtl/counter_load_ctrl.sv
// Load sequencer for a loadable wrap counter: queues {imm, val} requests in an
// in-order FIFO and issues immediate load pulses or deferred wrap-reload values.
module counter_load_ctrl #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [W-1:0]             req_val_i,
    input  logic                     req_imm_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             count_i,
    output logic                     load_o,
    output logic [W-1:0]             load_val_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    // Count value one step before the natural wrap (all ones minus one).
    localparam logic [W-1:0]  ARM_COUNT  = {{(W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ARMED
    } state_t;

    typedef struct packed {
        logic         imm;
        logic [W-1:0] val;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    state_t         state;

    entry_t         head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    assign head        = mem[rd_ptr];
    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == FULL_LEVEL);

    // Ready depends only on the registered level, so a full FIFO refuses a
    // push even when the same cycle pops.
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i && !fifo_full && !flush_i;

    always_comb begin
        // NOTE: default first so every path assigns pop and no latch is inferred.
        pop = 1'b0;
        if (state == ISSUE) begin
            pop = 1'b1;
        end else if (state == ARMED && count_i == ARM_COUNT) begin
            pop = 1'b1;
        end
    end

    // NOTE: storage is not reset; level and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{imm: req_imm_i, val: req_val_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sequencer: load_o is a one-cycle pulse; load_val_o holds the last popped
    // value so it doubles as the counter's wrap-reload value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            load_o     <= 1'b0;
            load_val_o <= '0;
        end else begin
            load_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= head.imm ? ISSUE : ARMED;
                    end
                end
                ISSUE: begin
                    load_o     <= 1'b1;
                    load_val_o <= head.val;
                    state      <= IDLE;
                end
                ARMED: begin
                    if (count_i == ARM_COUNT) begin
                        load_val_o <= head.val;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A flush abandons the queue but lets this edge's output update stand.
            if (flush_i) begin
                state <= IDLE;
            end
        end
    end

    assign fifo_level_o = level;
    assign busy_o       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Bench for counter_load_ctrl: queue-level reference model compared every cycle,
// a small wrap counter closing the count_i loop, and directed literal checks.
module tb_counter_load_ctrl;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_imm = 1'b0;
    logic [3:0] req_val = '0;
    logic       flush = 1'b0;
    logic [3:0] cnt;
    logic       req_ready;
    logic       load;
    logic [3:0] load_val;
    logic [2:0] level;
    logic       busy;

    counter_load_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_val_i    (req_val),
        .req_imm_i    (req_imm),
        .flush_i      (flush),
        .count_i      (cnt),
        .load_o       (load),
        .load_val_o   (load_val),
        .fifo_level_o (level),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External wrap counter: load pulse wins, otherwise F wraps to load_val.
    logic       cnt_hold = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset)            cnt <= '0;
        else if (force_en)     cnt <= force_val;
        else if (cnt_hold)     cnt <= cnt;
        else if (load)         cnt <= load_val;
        else if (cnt == 4'hF)  cnt <= load_val;
        else                   cnt <= cnt + 4'd1;
    end

    // Reference model: a request queue plus a flag saying the head has been
    // picked up. A picked-up immediate head leaves next edge with a pulse; a
    // picked-up deferred head leaves on the edge where the count reads E.
    typedef struct {
        bit         imm;
        logic [3:0] val;
    } req_t;

    req_t       q[$];
    bit         engaged;
    bit         m_load;
    logic [3:0] m_val;
    bit         take;
    bit         leave;
    bit         nxt_engaged;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            engaged = 1'b0;
            m_load  = 1'b0;
            m_val   = '0;
        end else begin
            take   = req_valid && (q.size() < DEPTH) && !flush;
            leave  = 1'b0;
            m_load = 1'b0;
            if (engaged) begin
                if (q[0].imm) begin
                    leave  = 1'b1;
                    m_load = 1'b1;
                    m_val  = q[0].val;
                end else if (cnt == 4'hE) begin
                    leave  = 1'b1;
                    m_val  = q[0].val;
                end
            end
            if (flush || leave)      nxt_engaged = 1'b0;
            else if (q.size() != 0)  nxt_engaged = 1'b1;
            else                     nxt_engaged = engaged;
            if (flush) begin
                q.delete();
            end else begin
                if (leave) void'(q.pop_front());
                if (take)  q.push_back('{imm: req_imm, val: req_val});
            end
            engaged = nxt_engaged;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && reset) begin
            check("cmp_load", load, m_load);
            check("cmp_load_val", load_val, m_val);
            check("cmp_level", level, q.size());
            check("cmp_ready", req_ready, q.size() < DEPTH);
            check("cmp_busy", busy, engaged || q.size() != 0);
        end
    end

    // Returns on the negedge after the accepting edge.
    task automatic push(input bit imm, input logic [3:0] v);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_imm   = imm;
        req_val   = v;
        for (int i = 0; i < 50; i++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) break;
        end
        req_valid = 1'b0;
        check("push_accept", acc, 1);
    endtask

    bit found;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_load", load, 0);
        check("rst_load_val", load_val, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Immediate 9: pulse in the cycle after the second edge past acceptance.
        push(1'b1, 4'h9);
        check("t1_level_acc", level, 1);
        check("t1_no_pulse0", load, 0);
        @(negedge clk);
        check("t1_no_pulse1", load, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_pulse", load, 1);
        check("t1_val", load_val, 4'h9);
        check("t1_level_done", level, 0);
        @(negedge clk);
        check("t1_pulse_end", load, 0);
        check("t1_val_hold", load_val, 4'h9);
        repeat (2) @(negedge clk);

        // Deferred 3 while count is 5: counter goes E, F, 3.
        force_val = 4'h5; force_en = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        push(1'b0, 4'h3);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt == 4'hE) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("t2_reach_e", found, 1);
        check("t2_val_before", load_val, 4'h9);
        @(negedge clk);
        check("t2_val_after", load_val, 4'h3);
        check("t2_cnt_f", cnt, 4'hF);
        check("t2_no_pulse", load, 0);
        @(negedge clk);
        check("t2_cnt_reload", cnt, 4'h3);

        // Fill four deferred entries with the counter parked at 0.
        force_val = 4'h0; force_en = 1'b1; cnt_hold = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        push(1'b0, 4'h1);
        push(1'b0, 4'h2);
        push(1'b0, 4'h3);
        push(1'b0, 4'h4);
        check("t3_level_full", level, 4);
        check("t3_not_ready", req_ready, 0);
        req_valid = 1'b1; req_imm = 1'b0; req_val = 4'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_refused", level, 4);
        end
        cnt_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin found = 1'b1; break; end
        end
        check("t3_ready_back", found, 1);
        check("t3_level_pop", level, 3);
        check("t3_pop_val", load_val, 4'h1);
        @(negedge clk);
        check("t3_refill", level, 4);
        flush = 1'b1; req_val = 4'h6;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("t3_flush_level", level, 0);
        check("t3_flush_busy", busy, 0);

        // Deferred 2 blocks immediate C until the wrap pop.
        push(1'b0, 4'h2);
        push(1'b1, 4'hC);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load_val == 4'h2) begin found = 1'b1; break; end
            check("t4_blocked", load, 0);
        end
        check("t4_deferred_pop", found, 1);
        check("t4_no_pulse0", load, 0);
        @(negedge clk);
        check("t4_no_pulse1", load, 0);
        @(negedge clk);
        check("t4_pulse", load, 1);
        check("t4_pulse_val", load_val, 4'hC);
        repeat (3) @(negedge clk);
        check("t4_idle", busy, 0);

        // Push at level 3 during an immediate pop.
        force_val = 4'h0; force_en = 1'b1; cnt_hold = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        push(1'b0, 4'h7);
        push(1'b1, 4'hA);
        push(1'b1, 4'hB);
        check("t5_level3", level, 3);
        force_val = 4'hE; force_en = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        check("t5_def_pop_level", level, 2);
        check("t5_def_pop_val", load_val, 4'h7);
        req_valid = 1'b1; req_imm = 1'b1; req_val = 4'hC;
        @(negedge clk);
        check("t5_level_push", level, 3);
        req_val = 4'hD;
        @(negedge clk);
        check("t5_level_same", level, 3);
        check("t5_pulse_a", load, 1);
        check("t5_val_a", load_val, 4'hA);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_val_b", load_val, 4'hB);
        repeat (2) @(negedge clk);
        check("t5_val_c", load_val, 4'hC);
        repeat (2) @(negedge clk);
        check("t5_val_d", load_val, 4'hD);
        check("t5_pulse_d", load, 1);
        check("t5_level_empty", level, 0);

        // Reset while armed with two queued, then flush with three queued.
        force_val = 4'h0; force_en = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        push(1'b0, 4'h1);
        push(1'b0, 4'h2);
        @(negedge clk);
        check("t6_armed_level", level, 2);
        check("t6_armed_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_load", load, 0);
        check("t6_rst_val", load_val, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        push(1'b0, 4'h4);
        push(1'b0, 4'h5);
        push(1'b0, 4'h6);
        check("t6_level3", level, 3);
        flush = 1'b1; req_valid = 1'b1; req_imm = 1'b1; req_val = 4'h9;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("t6_flush_level", level, 0);
        check("t6_flush_busy", busy, 0);
        push(1'b1, 4'h8);
        repeat (2) @(negedge clk);
        check("t6_after_flush_pulse", load, 1);
        check("t6_after_flush_val", load_val, 4'h8);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
